layer_compositor: RTL and testbench

Parametrised successor to the fixed four-layer compositor: redraws the whole VRAM frame once per `frame_start` from one tiled background plus `NUM_SPR` generic sprite channels (ball, holes, future objects), each with enable, slot select and transparency keying. Sits between the game logic (positions) and the sprite-buffer ROM / VRAM write port, triggered by the VGA timing's `screenend` pulse.

---
 rtl/layer_compositor_pkg.sv | 14 +
 rtl/layer_compositor_if.sv | 15 +
 rtl/layer_compositor_sprite_hit.sv | 25 ++
 rtl/layer_compositor.sv | 148 ++++++++++++++
 tb/tb_layer_compositor.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared types and helpers for the layer compositor: FSM states, pixel format
// and the sprite-buffer slot addressing rule.
package layer_pkg;
  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'hF0F;

  typedef enum logic [1:0] {S_IDLE, S_BG, S_CH, S_WR} state_e;

  // Texel address inside the sprite buffer: slots are stacked s*s texel tiles.
  function automatic int unsigned slot_addr(input int unsigned slot, input int unsigned ty,
                                            input int unsigned tx, input int unsigned s);
    return slot * s * s + ty * s + tx;
  endfunction
endpackage

// File: rtl/layer_compositor_if.sv
// Memory-side bus of the compositor: sprite-buffer read port and VRAM write port.
interface layer_compositor_if #(
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 13,
  parameter int COLOR_W           = 12
);
  logic [SPRITEBUF_A_WIDTH-1:0] sprbuf_addr;
  logic [COLOR_W-1:0]           sprbuf_data;
  logic [VRAM_A_WIDTH-1:0]      vram_addr;
  logic [COLOR_W-1:0]           vram_data;
  logic                         vram_we;

  modport master (output sprbuf_addr, vram_addr, vram_data, vram_we, input sprbuf_data);
  modport slave  (input sprbuf_addr, vram_addr, vram_data, vram_we, output sprbuf_data);
endinterface

// File: rtl/layer_compositor_sprite_hit.sv
// Per-channel coverage test: does pixel (x,y) fall inside this sprite, and at
// which texel. The edge sum is 11 bits so sprites near 1023 never wrap to 0.
module sprite_hit #(
  parameter int SPRITE_SIZE = 32
) (
  input  logic [9:0]                     i_x,
  input  logic [9:0]                     i_y,
  input  logic [9:0]                     i_px,
  input  logic [9:0]                     i_py,
  input  logic                           i_en,
  output logic                           o_hit,
  output logic [$clog2(SPRITE_SIZE)-1:0] o_tx,
  output logic [$clog2(SPRITE_SIZE)-1:0] o_ty
);
  localparam int LOG_S = $clog2(SPRITE_SIZE);

  logic [10:0] w_xe, w_ye;

  assign w_xe  = {1'b0, i_px} + 11'(SPRITE_SIZE);
  assign w_ye  = {1'b0, i_py} + 11'(SPRITE_SIZE);
  assign o_hit = i_en && (i_x >= i_px) && ({1'b0, i_x} < w_xe)
                      && (i_y >= i_py) && ({1'b0, i_y} < w_ye);
  assign o_tx  = LOG_S'(i_x - i_px);
  assign o_ty  = LOG_S'(i_y - i_py);
endmodule

// File: rtl/layer_compositor.sv
// Full-frame redraw: per pixel one background read, one read per sprite
// channel, then a VRAM write of the merged colour. Fixed NUM_SPR+2 cycles/pixel.
module layer_compositor #(
  parameter int VRAM_A_WIDTH      = 16,
  parameter int SPRITEBUF_A_WIDTH = 13,
  parameter int SCREEN_WIDTH      = 320,
  parameter int SCREEN_HEIGHT     = 180,
  parameter int SPRITE_SIZE       = 32,
  parameter int NUM_SPR           = 7,
  parameter int SLOT_W            = 3,
  parameter int BG_SLOT           = 0,
  parameter int COLOR_W           = layer_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = layer_pkg::TRANSPARENT
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [10*NUM_SPR-1:0]     i_pos_x,
  input  logic [10*NUM_SPR-1:0]     i_pos_y,
  input  logic [SLOT_W*NUM_SPR-1:0] i_slot,
  input  logic [NUM_SPR-1:0]        i_en,
  layer_compositor_if.master        bus,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);
  import layer_pkg::*;

  localparam int LOG_S = $clog2(SPRITE_SIZE);
  localparam int KW    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SPR - 1);
  localparam logic [9:0]    X_LAST = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]    Y_LAST = 10'(SCREEN_HEIGHT - 1);

  state_e                          r_state;
  logic [9:0]                      r_x, r_y;
  logic [KW-1:0]                   r_k;
  logic [NUM_SPR-1:0][9:0]         r_px, r_py;
  logic [NUM_SPR-1:0][SLOT_W-1:0]  r_slot;
  logic [NUM_SPR-1:0]              r_en;
  logic [COLOR_W-1:0]              r_col;
  logic                            r_rd_bg, r_rd_hit, r_we;

  logic [NUM_SPR-1:0]              w_hit;
  logic [NUM_SPR-1:0][LOG_S-1:0]   w_tx, w_ty;
  logic [KW-1:0]                   w_nk;
  logic [9:0]                      w_nx, w_ny;
  logic                            w_last_px;
  logic [COLOR_W-1:0]              w_col_in;
  logic [SPRITEBUF_A_WIDTH-1:0]    w_ch_addr, w_bg_addr;

  for (genvar k = 0; k < NUM_SPR; k++) begin : g_hit
    sprite_hit #(.SPRITE_SIZE(SPRITE_SIZE)) u_hit (
      .i_x(r_x), .i_y(r_y), .i_px(r_px[k]), .i_py(r_py[k]), .i_en(r_en[k]),
      .o_hit(w_hit[k]), .o_tx(w_tx[k]), .o_ty(w_ty[k])
    );
  end

  // Addresses are registered one state ahead: BG/CH set up the next channel's
  // read, WR sets up the next pixel's background read.
  always_comb begin
    w_nk      = (r_state == S_CH && r_k != K_LAST) ? r_k + 1'b1 : '0;
    w_nx      = (r_x == X_LAST) ? '0 : r_x + 1'b1;
    w_ny      = (r_x == X_LAST) ? r_y + 1'b1 : r_y;
    w_last_px = (r_x == X_LAST) && (r_y == Y_LAST);
    w_ch_addr = SPRITEBUF_A_WIDTH'(slot_addr(32'(r_slot[w_nk]), 32'(w_ty[w_nk]),
                                             32'(w_tx[w_nk]), SPRITE_SIZE));
    w_bg_addr = SPRITEBUF_A_WIDTH'(slot_addr(BG_SLOT, 32'(w_ny[LOG_S-1:0]),
                                             32'(w_nx[LOG_S-1:0]), SPRITE_SIZE));
    // Background data is always taken; sprite data only on a hit and not keyed out.
    w_col_in  = r_col;
    if (r_rd_bg || (r_rd_hit && bus.sprbuf_data != TRANSPARENT))
      w_col_in = bus.sprbuf_data;
  end

  // The last channel's data arrives during WR, so the written colour merges it live.
  assign bus.vram_data = r_we ? w_col_in : '0;
  assign bus.vram_we   = r_we;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_k             <= '0;
      r_px            <= '0;
      r_py            <= '0;
      r_slot          <= '0;
      r_en            <= '0;
      r_col           <= '0;
      r_rd_bg         <= 1'b0;
      r_rd_hit        <= 1'b0;
      r_we            <= 1'b0;
      bus.sprbuf_addr <= '0;
      bus.vram_addr   <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      r_we       <= 1'b0;
      r_rd_bg    <= (r_state == S_BG);
      r_rd_hit   <= (r_state == S_CH) && w_hit[r_k];
      r_col      <= w_col_in;
      if (frame_start && r_state != S_IDLE) overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (frame_start) begin
          r_px            <= i_pos_x;
          r_py            <= i_pos_y;
          r_slot          <= i_slot;
          r_en            <= i_en;
          r_x             <= '0;
          r_y             <= '0;
          busy            <= 1'b1;
          bus.sprbuf_addr <= SPRITEBUF_A_WIDTH'(slot_addr(BG_SLOT, 0, 0, SPRITE_SIZE));
          r_state         <= S_BG;
        end
        S_BG: begin
          r_k             <= '0;
          bus.sprbuf_addr <= w_ch_addr;
          r_state         <= S_CH;
        end
        S_CH: if (r_k == K_LAST) begin
          r_we          <= 1'b1;
          bus.vram_addr <= VRAM_A_WIDTH'(32'(r_y) * 32'(SCREEN_WIDTH) + 32'(r_x));
          r_state       <= S_WR;
        end else begin
          r_k             <= w_nk;
          bus.sprbuf_addr <= w_ch_addr;
        end
        S_WR: begin
          r_x <= w_nx;
          if (w_last_px) begin
            r_y        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_y             <= w_ny;
            bus.sprbuf_addr <= w_bg_addr;
            r_state         <= S_BG;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench: 8x4 screen, 4x4 sprites, two channels, 1-cycle sprite ROM.
module tb_layer_compositor;
  logic        clk, rst_n, frame_start;
  logic [19:0] pos_x, pos_y;
  logic [5:0]  slot;
  logic [1:0]  en;
  logic        busy, frame_done, overrun;
  int          n_tot = 0, n_pass = 0;
  logic [11:0] cap [0:4][0:31];

  typedef struct { int sc; int addr; logic [11:0] exp; } vec_t;
  vec_t tbl [26];

  layer_compositor_if #(.VRAM_A_WIDTH(16), .SPRITEBUF_A_WIDTH(8), .COLOR_W(12)) bus ();

  layer_compositor #(
    .VRAM_A_WIDTH(16), .SPRITEBUF_A_WIDTH(8), .SCREEN_WIDTH(8), .SCREEN_HEIGHT(4),
    .SPRITE_SIZE(4), .NUM_SPR(2), .SLOT_W(3), .BG_SLOT(0)
  ) dut (
    .CLK(clk), .rst(rst_n), .frame_start(frame_start), .i_pos_x(pos_x), .i_pos_y(pos_y),
    .i_slot(slot), .i_en(en), .bus(bus), .busy(busy), .frame_done(frame_done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM texel {slot,ty,tx}; slot0 (3,3) equals the key, slot2 columns 0-1 are keyed out.
  function automatic logic [11:0] tex(input logic [7:0] a);
    logic [3:0] s, ty, tx;
    s = {1'b0, a[6:4]}; ty = {2'b0, a[3:2]}; tx = {2'b0, a[1:0]};
    if (s == 0 && tx == 3 && ty == 3) return 12'hF0F;
    if (s == 2 && tx < 2) return 12'hF0F;
    return {s, ty, tx};
  endfunction

  always @(posedge clk) bus.sprbuf_data <= tex(bus.sprbuf_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_cfg(input int sc);
    case (sc)
      1, 4: begin pos_x = {10'd0, 10'd2}; pos_y = {10'd0, 10'd1}; slot = {3'd0, 3'd1}; en = 2'b01; end
      2:    begin pos_x = {10'd2, 10'd0}; pos_y = {10'd2, 10'd0}; slot = {3'd3, 3'd1}; en = 2'b11; end
      3:    begin pos_x = {10'd3, 10'd0}; pos_y = '0;             slot = {3'd2, 3'd1}; en = 2'b11; end
      default: begin pos_x = '0; pos_y = '0; slot = '0; en = 2'b00; end
    endcase
  endtask

  task automatic run_frame(input int sc, input bit poke);
    int cyc, nwr, first_we, done_cyc;
    bit order_ok, busy_at_done;
    nwr = 0; first_we = -1; done_cyc = -1; order_ok = 1; busy_at_done = 1;
    set_cfg(sc);
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    cyc = 1;
    check($sformatf("s%0d_busy_rise", sc), busy, 1);
    while (cyc < 400 && done_cyc < 0) begin
      if (bus.vram_we) begin
        if (first_we < 0) first_we = cyc;
        if (bus.vram_addr != 16'(nwr)) order_ok = 0;
        cap[sc][bus.vram_addr[4:0]] = bus.vram_data;
        nwr++;
      end
      if (frame_done) begin done_cyc = cyc; busy_at_done = busy; end
      if (poke && cyc == 40) begin
        pos_x = {10'd4, 10'd0}; pos_y = {10'd2, 10'd0}; slot = {3'd1, 3'd3}; en = 2'b11;
        frame_start = 1'b1;
      end else if (poke && cyc == 41) frame_start = 1'b0;
      @(posedge clk); #1 cyc++;
    end
    check($sformatf("s%0d_nwrites", sc), nwr, 32);
    check($sformatf("s%0d_addr_order", sc), order_ok, 1);
    check($sformatf("s%0d_first_we", sc), first_we, 4);
    check($sformatf("s%0d_done_cyc", sc), done_cyc, 129);
    check($sformatf("s%0d_busy_at_done", sc), busy_at_done, 0);
  endtask

  initial begin
    int cyc;
    bit seen, rose;
    tbl = '{
      '{0, 0, 12'h000}, '{0, 5, 12'h001}, '{0, 15, 12'h013}, '{0, 20, 12'h020}, '{0, 31, 12'hF0F},
      '{1, 10, 12'h100}, '{1, 29, 12'h123}, '{1, 9, 12'h011}, '{1, 14, 12'h012}, '{1, 3, 12'h003},
      '{1, 20, 12'h112},
      '{2, 18, 12'h300}, '{2, 27, 12'h311}, '{2, 9, 12'h111}, '{2, 11, 12'h113}, '{2, 20, 12'h302},
      '{2, 5, 12'h001},
      '{3, 3, 12'h103}, '{3, 12, 12'h010}, '{3, 21, 12'h222}, '{3, 30, 12'h233}, '{3, 7, 12'h003},
      '{4, 10, 12'h100}, '{4, 9, 12'h011}, '{4, 0, 12'h000}, '{4, 20, 12'h112}
    };
    rst_n = 1'b0; frame_start = 1'b0; set_cfg(0);
    #12;
    check("rst_sprbuf_addr", bus.sprbuf_addr, 0);
    check("rst_vram_addr", bus.vram_addr, 0);
    check("rst_vram_data", bus.vram_data, 0);
    check("rst_vram_we", bus.vram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int s = 0; s < 4; s++) run_frame(s, 1'b0);
    check("no_overrun_normal", overrun, 0);

    // frame_start in the frame_done cycle is accepted without overrun
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (frame_done) seen = 1; else begin @(posedge clk); #1; end
    end
    check("b2b_done_seen", seen, 1);
    frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_no_overrun", overrun, 0);

    // reset mid-frame, right while a write is on the bus
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.vram_we) seen = 1; else begin @(posedge clk); #1; end
    end
    check("midrst_we_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_vram_we", bus.vram_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_vram_addr", bus.vram_addr, 0);
    check("midrst_vram_data", bus.vram_data, 0);
    check("midrst_sprbuf_addr", bus.sprbuf_addr, 0);
    @(posedge clk); #1;
    check("midrst_we_held", bus.vram_we, 0);
    rst_n = 1'b1;

    run_frame(4, 1'b1);
    check("overrun_set", overrun, 1);
    rose = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (busy) rose = 1;
    end
    check("second_start_ignored", rose, 0);
    check("overrun_sticky", overrun, 1);
    #2 rst_n = 1'b0;
    #1 check("overrun_cleared", overrun, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++)
      check($sformatf("pix_s%0d_a%0d", tbl[i].sc, tbl[i].addr), cap[tbl[i].sc][tbl[i].addr], tbl[i].exp);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
